// File: rtl/peri_bus_pkg.sv
// Shared types and constants for the core-0 peripheral port responder.
// Holds the bus FSM state encoding, the fixed error read-data patterns and the position of the
// slave-index field inside the byte address.
package peri_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERR    = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [31:0] RDATA_UNMAPPED = 32'hDEAD_BEEF;
    localparam logic [31:0] RDATA_TIMEOUT  = 32'hFFFF_FFFF;

    // Slave select field inside the byte address
    localparam int unsigned SLV_IDX_HI = 19;
    localparam int unsigned SLV_IDX_LO = 16;
    localparam int unsigned SLV_IDX_W  = SLV_IDX_HI - SLV_IDX_LO + 1;

endpackage

// File: rtl/peri_irq_ctrl.sv
// Interrupt bitmap for the peripheral slaves.
// Detects rising edges on the level irq lines, keeps one pending bit per slave at bitmap position
// IRQ_BASE+k and clears a bit when the core acknowledges it. A new edge beats a same-cycle ack.
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_slv_irq         level irq per slave
//   i_irq_ack         core acknowledges the bit selected by i_irq_id
//   i_irq_id          bitmap index being acknowledged
//   o_irq_bitmap      pending bits; everything outside the slave window reads 0
module peri_irq_ctrl #(
    parameter int unsigned NUM_SLV  = 4,
    parameter int unsigned IRQ_BASE = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_SLV-1:0] i_slv_irq,
    input  logic               i_irq_ack,
    input  logic [4:0]         i_irq_id,
    output logic [31:0]        o_irq_bitmap
);

    logic [NUM_SLV-1:0] irq_q;
    logic [NUM_SLV-1:0] pend_q, pend_d;
    logic [NUM_SLV-1:0] rise;
    logic [NUM_SLV-1:0] clr;

    assign rise = i_slv_irq & ~irq_q;

    always_comb begin
        clr = '0;
        for (int unsigned k = 0; k < NUM_SLV; k++) begin
            clr[k] = i_irq_ack && (i_irq_id == 5'(IRQ_BASE + k));
        end
        // OR-ing the edge in last lets a set override a same-cycle clear
        pend_d = (pend_q & ~clr) | rise;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_q  <= '0;
            pend_q <= '0;
        end else begin
            irq_q  <= i_slv_irq;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        o_irq_bitmap = '0;
        o_irq_bitmap[IRQ_BASE +: NUM_SLV] = pend_q;
    end

endmodule

// File: rtl/peri_bus_responder.sv
// Target end of the core-0 peripheral port.
// Accepts one read/write at a time while idle, decodes it to one of NUM_SLV slaves, holds the
// one-hot slave request until that slave acks (or the timeout expires) and returns a single
// o_peri_ready pulse. Unmapped addresses and timeouts return fixed patterns and bump a saturating
// error counter. The irq bitmap is produced by peri_irq_ctrl.
// Ports:
//   i_peri_*      initiator request (rden/wren/addr/wdata/wstrb)
//   o_peri_*      response: rdata (valid with ready), ready pulse, gnt (idle)
//   o_slv_*       request towards the selected slave, i_slv_rdata/i_slv_ack per-slave completion
//   i_slv_irq     level irqs, o_irq_bitmap/i_irq_ack/i_irq_id interrupt interface
//   o_err_cnt     saturating count of unmapped and timed-out accesses
module peri_bus_responder
    import peri_bus_pkg::*;
#(
    parameter int unsigned NUM_SLV  = 4,
    parameter logic [11:0] BASE_HI  = 12'h100,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned IRQ_BASE = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_peri_rden,
    input  logic                   i_peri_wren,
    input  logic [31:0]            i_peri_addr,
    input  logic [31:0]            i_peri_wdata,
    input  logic [3:0]             i_peri_wstrb,
    output logic [31:0]            o_peri_rdata,
    output logic                   o_peri_ready,
    output logic                   o_peri_gnt,
    output logic [NUM_SLV-1:0]     o_slv_req,
    output logic                   o_slv_we,
    output logic [15:0]            o_slv_addr,
    output logic [31:0]            o_slv_wdata,
    output logic [3:0]             o_slv_wstrb,
    input  logic [NUM_SLV*32-1:0]  i_slv_rdata,
    input  logic [NUM_SLV-1:0]     i_slv_ack,
    input  logic [NUM_SLV-1:0]     i_slv_irq,
    output logic [31:0]            o_irq_bitmap,
    input  logic                   i_irq_ack,
    input  logic [4:0]             i_irq_id,
    output logic [15:0]            o_err_cnt
);

    localparam int unsigned   TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic                   we_q, we_d;
    logic [15:0]            addr_q, addr_d;
    logic [SLV_IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wstrb_q, wstrb_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   acked_q, acked_d;
    logic [31:0]            cap_q, cap_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [15:0]            err_cnt_q, err_cnt_d;

    logic                   mapped;
    logic                   err_inc;
    logic                   sel_ack;
    logic [31:0]            sel_rdata;
    logic [NUM_SLV-1:0]     slv_req;

    assign mapped = (i_peri_addr[31:20] == BASE_HI) &&
                    (32'(i_peri_addr[SLV_IDX_HI:SLV_IDX_LO]) < NUM_SLV);

    // Only the slave being addressed can complete the access; the others are ignored.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        slv_req   = '0;
        for (int unsigned k = 0; k < NUM_SLV; k++) begin
            if (idx_q == SLV_IDX_W'(k)) begin
                sel_ack    = i_slv_ack[k];
                sel_rdata  = i_slv_rdata[k*32 +: 32];
                slv_req[k] = (state_q == ACCESS) && !acked_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        timer_d = timer_q;
        acked_d = acked_q;
        cap_d   = cap_q;
        rdata_d = rdata_q;
        err_inc = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_peri_rden || i_peri_wren) begin
                    we_d    = i_peri_wren;
                    addr_d  = i_peri_addr[15:0];
                    idx_d   = i_peri_addr[SLV_IDX_HI:SLV_IDX_LO];
                    wdata_d = i_peri_wdata;
                    wstrb_d = i_peri_wstrb;
                    timer_d = '0;
                    acked_d = 1'b0;
                    state_d = mapped ? ACCESS : ERR;
                end
            end
            ACCESS: begin
                // The ack is absorbed into cap_q first so the request drops before RESP and
                // o_peri_rdata only changes when the response is issued.
                if (acked_q) begin
                    rdata_d = cap_q;
                    state_d = RESP;
                end else if (sel_ack) begin
                    acked_d = 1'b1;
                    cap_d   = we_q ? 32'h0 : sel_rdata;
                end else if (timer_q == TIMER_LAST) begin
                    rdata_d = RDATA_TIMEOUT;
                    err_inc = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ERR: begin
                rdata_d = RDATA_UNMAPPED;
                err_inc = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        err_cnt_d = (err_inc && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            timer_q   <= '0;
            acked_q   <= 1'b0;
            cap_q     <= '0;
            rdata_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            timer_q   <= timer_d;
            acked_q   <= acked_d;
            cap_q     <= cap_d;
            rdata_q   <= rdata_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_peri_gnt   = (state_q == IDLE);
    assign o_peri_ready = (state_q == RESP);
    assign o_peri_rdata = rdata_q;
    assign o_slv_req    = slv_req;
    assign o_slv_we     = we_q;
    assign o_slv_addr   = addr_q;
    assign o_slv_wdata  = wdata_q;
    assign o_slv_wstrb  = wstrb_q;
    assign o_err_cnt    = err_cnt_q;

    peri_irq_ctrl #(
        .NUM_SLV  (NUM_SLV),
        .IRQ_BASE (IRQ_BASE)
    ) u_irq_ctrl (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_slv_irq    (i_slv_irq),
        .i_irq_ack    (i_irq_ack),
        .i_irq_id     (i_irq_id),
        .o_irq_bitmap (o_irq_bitmap)
    );

endmodule

// File: tb/tb_peri_bus_responder.sv
// Bench for peri_bus_responder: directed scenarios plus randomized bus and irq traffic checked
// against expectations computed from the access rules (latency, data, error counting, bitmap).
module tb_peri_bus_responder;

    logic         clk;
    logic         rst_n;
    logic         peri_rden, peri_wren;
    logic [31:0]  peri_addr, peri_wdata;
    logic [3:0]   peri_wstrb;
    logic [31:0]  peri_rdata;
    logic         peri_ready, peri_gnt;
    logic [3:0]   slv_req;
    logic         slv_we;
    logic [15:0]  slv_addr;
    logic [31:0]  slv_wdata;
    logic [3:0]   slv_wstrb;
    logic [127:0] slv_rdata;
    logic [3:0]   slv_ack;
    logic [3:0]   slv_irq;
    logic [31:0]  irq_bitmap;
    logic         irq_ack;
    logic [4:0]   irq_id;
    logic [15:0]  err_cnt;

    int          n_tests;
    int          n_fail;
    logic [15:0] err_exp;

    // Observations of the most recent access
    int          obs_lat, obs_req_cycles;
    logic [3:0]  obs_req_or;
    logic        obs_we, obs_gnt_low_ok, obs_gnt_at_ready, obs_ready_after, obs_gnt_after;
    logic        obs_to;
    logic [15:0] obs_addr;
    logic [31:0] obs_wdata, obs_rdata;
    logic [3:0]  obs_wstrb;

    peri_bus_responder #(
        .NUM_SLV  (4),
        .BASE_HI  (12'h100),
        .TIMEOUT  (64),
        .IRQ_BASE (16)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_peri_rden  (peri_rden),
        .i_peri_wren  (peri_wren),
        .i_peri_addr  (peri_addr),
        .i_peri_wdata (peri_wdata),
        .i_peri_wstrb (peri_wstrb),
        .o_peri_rdata (peri_rdata),
        .o_peri_ready (peri_ready),
        .o_peri_gnt   (peri_gnt),
        .o_slv_req    (slv_req),
        .o_slv_we     (slv_we),
        .o_slv_addr   (slv_addr),
        .o_slv_wdata  (slv_wdata),
        .o_slv_wstrb  (slv_wstrb),
        .i_slv_rdata  (slv_rdata),
        .i_slv_ack    (slv_ack),
        .i_slv_irq    (slv_irq),
        .o_irq_bitmap (irq_bitmap),
        .i_irq_ack    (irq_ack),
        .i_irq_id     (irq_id),
        .o_err_cnt    (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Runs one access from an idle responder; the slave acks on `sel` after `ack_delay` request
    // cycles (-1 = never). `noise` adds random acks on the other slaves.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb,
                             input logic [3:0] sel, input int ack_delay,
                             input logic [31:0] sdata, input bit noise);
        logic [3:0] ack;
        obs_req_cycles = 0;
        obs_req_or     = '0;
        obs_gnt_low_ok = 1'b1;
        obs_we = 1'b0; obs_addr = '0; obs_wdata = '0; obs_wstrb = '0;
        @(negedge clk);
        peri_rden = rd; peri_wren = wr; peri_addr = addr; peri_wdata = wdata;
        peri_wstrb = wstrb;
        slv_ack = noise ? (4'($urandom) & ~sel) : 4'b0;
        @(negedge clk);
        peri_rden = 1'b0; peri_wren = 1'b0;
        peri_addr = $urandom; peri_wdata = $urandom; peri_wstrb = 4'($urandom);
        obs_lat = 1;
        while (!peri_ready && obs_lat < 200) begin
            if (peri_gnt) obs_gnt_low_ok = 1'b0;
            if (slv_req != 4'b0) begin
                if (obs_req_cycles == 0) begin
                    obs_we = slv_we; obs_addr = slv_addr;
                    obs_wdata = slv_wdata; obs_wstrb = slv_wstrb;
                end
                obs_req_or = obs_req_or | slv_req;
                obs_req_cycles++;
            end
            slv_rdata = {$urandom, $urandom, $urandom, $urandom};
            ack = noise ? (4'($urandom) & ~sel) : 4'b0;
            if (slv_req != 4'b0 && obs_req_cycles - 1 == ack_delay) begin
                ack = ack | sel;
                for (int k = 0; k < 4; k++) if (sel[k]) slv_rdata[k*32 +: 32] = sdata;
            end
            slv_ack = ack;
            @(negedge clk);
            obs_lat++;
        end
        obs_to           = !peri_ready;
        obs_rdata        = peri_rdata;
        obs_gnt_at_ready = peri_gnt;
        slv_ack = 4'b0;
        @(negedge clk);
        obs_ready_after = peri_ready;
        obs_gnt_after   = peri_gnt;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if (peri_gnt !== 1'b1 || peri_ready !== 1'b0 || peri_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_resp: gnt=%b ready=%b rdata=%h want 1 0 0",
                     peri_gnt, peri_ready, peri_rdata);
        end
        n_tests++;
        if (slv_req !== 4'b0 || slv_we !== 1'b0 || slv_addr !== 16'h0 ||
            slv_wdata !== 32'h0 || slv_wstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_slv: req=%b we=%b addr=%h wdata=%h strb=%h want all 0",
                     slv_req, slv_we, slv_addr, slv_wdata, slv_wstrb);
        end
        n_tests++;
        if (irq_bitmap !== 32'h0 || err_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_irq_err: bitmap=%h err=%h want 0 0", irq_bitmap, err_cnt);
        end
    endtask

    task automatic test_read_delayed_ack();
        do_access(1'b1, 1'b0, 32'h1002_0010, 32'h0, 4'hF, 4'b0100, 1, 32'h1234_5678, 1'b0);
        n_tests++;
        if (obs_to || obs_req_or !== 4'b0100 || obs_req_cycles != 2) begin
            n_fail++;
            $display("FAIL rd_req: to=%b req=%b cycles=%0d want 0 0100 2",
                     obs_to, obs_req_or, obs_req_cycles);
        end
        n_tests++;
        if (obs_rdata !== 32'h1234_5678 || obs_lat != 4) begin
            n_fail++;
            $display("FAIL rd_data: rdata=%h lat=%0d want 12345678 4", obs_rdata, obs_lat);
        end
        n_tests++;
        if (!obs_gnt_low_ok || obs_gnt_at_ready !== 1'b0 || obs_ready_after !== 1'b0 ||
            obs_gnt_after !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_handshake: gnt_low=%b gnt@rdy=%b rdy_after=%b gnt_after=%b",
                     obs_gnt_low_ok, obs_gnt_at_ready, obs_ready_after, obs_gnt_after);
        end
    endtask

    task automatic test_write_same_cycle();
        do_access(1'b0, 1'b1, 32'h1001_0004, 32'hA5A5_A5A5, 4'b0011, 4'b0010, 0,
                  32'h5555_0000, 1'b0);
        n_tests++;
        if (obs_req_or !== 4'b0010 || obs_we !== 1'b1 || obs_addr !== 16'h0004 ||
            obs_wdata !== 32'hA5A5_A5A5 || obs_wstrb !== 4'b0011) begin
            n_fail++;
            $display("FAIL wr_fields: req=%b we=%b addr=%h data=%h strb=%b",
                     obs_req_or, obs_we, obs_addr, obs_wdata, obs_wstrb);
        end
        n_tests++;
        if (obs_lat != 3 || obs_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL wr_latency: lat=%0d rdata=%h want 3 0", obs_lat, obs_rdata);
        end
    endtask

    task automatic test_unmapped();
        do_access(1'b1, 1'b0, 32'h2000_0000, 32'h0, 4'hF, 4'b0000, 0, 32'h0, 1'b0);
        err_exp++;
        n_tests++;
        if (obs_lat != 2 || obs_rdata !== 32'hDEAD_BEEF || obs_req_cycles != 0) begin
            n_fail++;
            $display("FAIL unmapped: lat=%0d rdata=%h req_cycles=%0d want 2 deadbeef 0",
                     obs_lat, obs_rdata, obs_req_cycles);
        end
        n_tests++;
        if (err_cnt !== err_exp) begin
            n_fail++;
            $display("FAIL unmapped_err: err=%0d want %0d", err_cnt, err_exp);
        end
    endtask

    task automatic test_timeout();
        do_access(1'b1, 1'b0, 32'h1003_0000, 32'h0, 4'hF, 4'b1000, -1, 32'h0, 1'b0);
        err_exp++;
        n_tests++;
        if (obs_req_or !== 4'b1000 || obs_req_cycles != 64 || obs_lat != 65) begin
            n_fail++;
            $display("FAIL timeout_req: req=%b cycles=%0d lat=%0d want 1000 64 65",
                     obs_req_or, obs_req_cycles, obs_lat);
        end
        n_tests++;
        if (obs_rdata !== 32'hFFFF_FFFF || err_cnt !== err_exp) begin
            n_fail++;
            $display("FAIL timeout_resp: rdata=%h err=%0d want ffffffff %0d",
                     obs_rdata, err_cnt, err_exp);
        end
    endtask

    task automatic test_back_to_back();
        int readies;
        readies = 0;
        @(negedge clk);
        peri_rden = 1'b1; peri_wren = 1'b0; peri_addr = 32'h3000_0000;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (peri_ready) readies++;
        end
        peri_rden = 1'b0;
        err_exp = err_exp + 16'd3;
        n_tests++;
        if (readies != 3 || err_cnt !== err_exp || peri_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL back_to_back: readies=%0d err=%0d rdata=%h want 3 %0d deadbeef",
                     readies, err_cnt, peri_rdata, err_exp);
        end
        @(negedge clk);
    endtask

    task automatic test_irq();
        @(negedge clk);
        slv_irq = 4'b0; irq_ack = 1'b0;
        @(negedge clk);
        for (int b = 16; b < 20; b++) begin
            irq_ack = 1'b1; irq_id = 5'(b);
            @(negedge clk);
        end
        irq_ack = 1'b0;
        n_tests++;
        if (irq_bitmap !== 32'h0) begin
            n_fail++; $display("FAIL irq_clear_all: bitmap=%h want 0", irq_bitmap);
        end
        slv_irq = 4'b0010;
        @(negedge clk);
        n_tests++;
        if (irq_bitmap !== 32'h0002_0000) begin
            n_fail++; $display("FAIL irq_edge: bitmap=%h want 00020000", irq_bitmap);
        end
        slv_irq = 4'b0000;
        @(negedge clk);
        slv_irq = 4'b0010; irq_ack = 1'b1; irq_id = 5'd17;
        @(negedge clk);
        irq_ack = 1'b0;
        n_tests++;
        if (irq_bitmap !== 32'h0002_0000) begin
            n_fail++; $display("FAIL irq_set_wins: bitmap=%h want 00020000", irq_bitmap);
        end
        irq_ack = 1'b1; irq_id = 5'd5;
        @(negedge clk);
        irq_ack = 1'b0;
        n_tests++;
        if (irq_bitmap !== 32'h0002_0000) begin
            n_fail++; $display("FAIL irq_ack_oob: bitmap=%h want 00020000", irq_bitmap);
        end
        irq_ack = 1'b1; irq_id = 5'd17;
        @(negedge clk);
        irq_ack = 1'b0;
        @(negedge clk);
        n_tests++;
        if (irq_bitmap !== 32'h0) begin
            n_fail++; $display("FAIL irq_ack_clear: bitmap=%h want 0", irq_bitmap);
        end
    endtask

    task automatic test_random_irq();
        logic [31:0] pend_m;
        logic [3:0]  prev_m, nirq;
        logic        ack;
        logic [4:0]  id;
        @(negedge clk);
        slv_irq = 4'b0; irq_ack = 1'b0;
        @(negedge clk);
        for (int b = 16; b < 20; b++) begin
            irq_ack = 1'b1; irq_id = 5'(b);
            @(negedge clk);
        end
        irq_ack = 1'b0;
        pend_m = '0;
        prev_m = '0;
        for (int it = 0; it < 200; it++) begin
            nirq = 4'($urandom);
            ack  = 1'($urandom);
            id   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(16, 19)) : 5'($urandom);
            slv_irq = nirq; irq_ack = ack; irq_id = id;
            for (int b = 0; b < 4; b++) begin
                if (nirq[b] && !prev_m[b]) pend_m[16+b] = 1'b1;
                else if (ack && id == 5'(16 + b)) pend_m[16+b] = 1'b0;
            end
            prev_m = nirq;
            @(negedge clk);
            n_tests++;
            if (irq_bitmap !== pend_m) begin
                n_fail++;
                $display("FAIL irq_random[%0d]: bitmap=%h want %h", it, irq_bitmap, pend_m);
            end
        end
        irq_ack = 1'b0;
    endtask

    task automatic test_random_bus();
        logic [31:0] a, wd, sd, exp_rdata;
        logic [3:0]  strb, sel;
        logic [1:0]  rw;
        logic        mapped_m;
        int          cat, d, exp_lat, exp_cyc;
        for (int t = 0; t < 30; t++) begin
            cat = $urandom_range(0, 3);
            a   = $urandom;
            if (cat < 2) begin
                a[31:20] = 12'h100; a[19:16] = 4'($urandom_range(0, 3));
            end else if (cat == 2) begin
                a[31:20] = 12'h100; a[19:16] = 4'($urandom_range(4, 15));
            end
            mapped_m = (a[31:20] == 12'h100) && (a[19:16] < 4'd4);
            sel = 4'b0;
            for (int k = 0; k < 4; k++) if (mapped_m && a[19:16] == 4'(k)) sel[k] = 1'b1;
            rw   = 2'($urandom_range(1, 3));
            wd   = $urandom;
            sd   = $urandom;
            strb = 4'($urandom);
            d    = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
            if (!mapped_m) begin
                exp_lat = 2; exp_rdata = 32'hDEAD_BEEF; exp_cyc = 0; err_exp++;
            end else if (d < 0) begin
                exp_lat = 65; exp_rdata = 32'hFFFF_FFFF; exp_cyc = 64; err_exp++;
            end else begin
                exp_lat = 3 + d; exp_rdata = rw[1] ? 32'h0 : sd; exp_cyc = d + 1;
            end
            do_access(rw[0], rw[1], a, wd, strb, sel, d, sd, 1'b1);
            n_tests++;
            if (obs_to || obs_lat != exp_lat || obs_rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL rnd_resp[%0d] addr=%h: lat=%0d rdata=%h want %0d %h",
                         t, a, obs_lat, obs_rdata, exp_lat, exp_rdata);
            end
            n_tests++;
            if (obs_req_or !== sel || obs_req_cycles != exp_cyc || err_cnt !== err_exp) begin
                n_fail++;
                $display("FAIL rnd_req[%0d]: req=%b cycles=%0d err=%0d want %b %0d %0d",
                         t, obs_req_or, obs_req_cycles, err_cnt, sel, exp_cyc, err_exp);
            end
            n_tests++;
            if (!obs_gnt_low_ok || obs_gnt_at_ready !== 1'b0 || obs_ready_after !== 1'b0 ||
                obs_gnt_after !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd_hs[%0d]: gnt_low=%b gnt@rdy=%b rdy_after=%b gnt_after=%b",
                         t, obs_gnt_low_ok, obs_gnt_at_ready, obs_ready_after, obs_gnt_after);
            end
            if (mapped_m) begin
                n_tests++;
                if (obs_we !== rw[1] || obs_addr !== a[15:0] || obs_wdata !== wd ||
                    obs_wstrb !== strb) begin
                    n_fail++;
                    $display("FAIL rnd_fields[%0d]: we=%b addr=%h wd=%h strb=%b want %b %h %h %b",
                             t, obs_we, obs_addr, obs_wdata, obs_wstrb, rw[1], a[15:0], wd,
                             strb);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int late_ready;
        late_ready = 0;
        @(negedge clk);
        slv_irq = 4'b0;
        @(negedge clk);
        slv_irq = 4'b0001; peri_rden = 1'b1; peri_addr = 32'h1003_0000;
        @(negedge clk);
        peri_rden = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (slv_req !== 4'b1000 || irq_bitmap[16] !== 1'b1 || err_cnt !== err_exp) begin
            n_fail++;
            $display("FAIL pre_reset: req=%b irq16=%b err=%0d want 1000 1 %0d",
                     slv_req, irq_bitmap[16], err_cnt, err_exp);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (slv_req !== 4'b0 || peri_ready !== 1'b0 || irq_bitmap !== 32'h0 ||
            err_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_reset: req=%b ready=%b bitmap=%h err=%h want 0 0 0 0",
                     slv_req, peri_ready, irq_bitmap, err_cnt);
        end
        @(negedge clk);
        slv_irq = 4'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (peri_gnt !== 1'b1 || slv_req !== 4'b0) begin
            n_fail++;
            $display("FAIL post_reset: gnt=%b req=%b want 1 0000", peri_gnt, slv_req);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (peri_ready) late_ready++;
        end
        n_tests++;
        if (late_ready != 0) begin
            n_fail++;
            $display("FAIL no_resp_after_reset: ready pulses=%0d want 0", late_ready);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; err_exp = '0;
        rst_n = 1'b0;
        peri_rden = 1'b0; peri_wren = 1'b0; peri_addr = '0; peri_wdata = '0; peri_wstrb = '0;
        slv_rdata = '0; slv_ack = '0; slv_irq = '0; irq_ack = 1'b0; irq_id = '0;
        #22 rst_n = 1'b1;
        test_reset();
        test_read_delayed_ack();
        test_write_same_cycle();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        test_irq();
        test_random_bus();
        test_random_irq();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
